// File: rtl/clearable_dual_port_ram.sv
// Single-clock palette/line RAM: lane-masked write port, write-first read port
// with 1- or 2-cycle latency, and a clear engine that sweeps every word to CLEAR_VALUE.
module clearable_dual_port_ram #(
    parameter int                    DATA_WIDTH     = 12,
    parameter int                    LANE_WIDTH     = 4,
    parameter int                    ADDRESS_SIZE   = 13,
    parameter int                    READ_LATENCY   = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = {DATA_WIDTH{1'b0}},
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [DATA_WIDTH-1:0]              write_data,
    input  logic [ADDRESS_SIZE-1:0]            write_address,
    input  logic                               write_enable,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   write_mask,
    input  logic [ADDRESS_SIZE-1:0]            read_address,
    input  logic                               read_enable,
    input  logic                               clear_request,
    output logic [DATA_WIDTH-1:0]              read_data,
    output logic                               read_valid,
    output logic                               busy
);

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDRESS = {ADDRESS_SIZE{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } clear_state_t;

    clear_state_t            state_r;
    logic [ADDRESS_SIZE-1:0] clear_address_r;
    logic [DATA_WIDTH-1:0]   memory_r [DEPTH];

    logic                    busy_s;
    logic [ADDRESS_SIZE-1:0] wr_address_s;
    logic [DATA_WIDTH-1:0]   wr_data_s;
    logic [LANES-1:0]        wr_lanes_s;
    logic [DATA_WIDTH-1:0]   read_word_s;

    logic [DATA_WIDTH-1:0]   stage_data_r;
    logic                    stage_valid_r;

    // Per-lane overlay of a new word onto an old word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      lane_enable
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (lane_enable[i]) begin
                result[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
            end else begin
                result[i*LANE_WIDTH +: LANE_WIDTH] = old_word[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        return result;
    endfunction

    // Select the write source (sweep owns the port while busy) and form the forwarded read word.
    always_comb begin
        busy_s = (state_r == ST_CLEARING);
        if (busy_s) begin
            wr_address_s = clear_address_r;
            wr_data_s    = CLEAR_VALUE;
            wr_lanes_s   = {LANES{1'b1}};
        end else begin
            wr_address_s = write_address;
            wr_data_s    = write_data;
            wr_lanes_s   = write_enable ? write_mask : {LANES{1'b0}};
        end
        if (wr_address_s == read_address) begin
            read_word_s = merge_lanes(memory_r[read_address], wr_data_s, wr_lanes_s);
        end else begin
            read_word_s = memory_r[read_address];
        end
    end

    // Lane-enabled storage array; intentionally not reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_lanes_s[i]) begin
                memory_r[wr_address_s][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data_s[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Clear engine: one word per cycle from address 0 to the last address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= CLEAR_ON_RESET ? ST_CLEARING : ST_IDLE;
            clear_address_r <= {ADDRESS_SIZE{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clear_request) begin
                        state_r <= ST_CLEARING;
                    end
                    clear_address_r <= {ADDRESS_SIZE{1'b0}};
                end
                ST_CLEARING: begin
                    if (clear_address_r == LAST_ADDRESS) begin
                        state_r         <= ST_IDLE;
                        clear_address_r <= {ADDRESS_SIZE{1'b0}};
                    end else begin
                        clear_address_r <= clear_address_r + ADDRESS_SIZE'(1);
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    clear_address_r <= {ADDRESS_SIZE{1'b0}};
                end
            endcase
        end
    end

    // First read stage: capture on request, hold otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_data_r  <= {DATA_WIDTH{1'b0}};
            stage_valid_r <= 1'b0;
        end else begin
            stage_valid_r <= read_enable;
            if (read_enable) begin
                stage_data_r <= read_word_s;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_latency_two
            logic [DATA_WIDTH-1:0] out_data_r;
            logic                  out_valid_r;

            // Output stage: data advances only behind a valid first stage so gaps hold.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_data_r  <= {DATA_WIDTH{1'b0}};
                    out_valid_r <= 1'b0;
                end else begin
                    out_valid_r <= stage_valid_r;
                    if (stage_valid_r) begin
                        out_data_r <= stage_data_r;
                    end
                end
            end

            assign read_data  = out_data_r;
            assign read_valid = out_valid_r;
        end else begin : g_latency_one
            assign read_data  = stage_data_r;
            assign read_valid = stage_valid_r;
        end
    endgenerate

    assign busy = busy_s;

endmodule

// File: tb/tb_clearable_dual_port_ram.sv
// Bench for clearable_dual_port_ram: latency-1 and latency-2 instances share stimulus
// and are checked every cycle against an array-based model, plus literal expectations.
module tb_clearable_dual_port_ram;

    localparam int DW    = 12;
    localparam int AS    = 4;
    localparam int DEPTH = 16;
    localparam logic [11:0] CV = 12'hABC;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] write_data = 12'h000;
    logic [3:0]  write_address = 4'h0;
    logic        write_enable = 1'b0;
    logic [2:0]  write_mask = 3'b000;
    logic [3:0]  read_address = 4'h0;
    logic        read_enable = 1'b0;
    logic        clear_request = 1'b0;

    logic [11:0] read_data1, read_data2;
    logic        read_valid1, read_valid2, busy1, busy2;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    clearable_dual_port_ram #(.DATA_WIDTH(DW), .LANE_WIDTH(4), .ADDRESS_SIZE(AS), .READ_LATENCY(1),
                              .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)) u_lat1 (
        .clock(clock), .reset(reset), .write_data(write_data), .write_address(write_address),
        .write_enable(write_enable), .write_mask(write_mask), .read_address(read_address),
        .read_enable(read_enable), .clear_request(clear_request), .read_data(read_data1),
        .read_valid(read_valid1), .busy(busy1));

    clearable_dual_port_ram #(.DATA_WIDTH(DW), .LANE_WIDTH(4), .ADDRESS_SIZE(AS), .READ_LATENCY(2),
                              .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)) u_lat2 (
        .clock(clock), .reset(reset), .write_data(write_data), .write_address(write_address),
        .write_enable(write_enable), .write_mask(write_mask), .read_address(read_address),
        .read_enable(read_enable), .clear_request(clear_request), .read_data(read_data2),
        .read_valid(read_valid2), .busy(busy2));

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Model: memory contents, remaining sweep cycles, and expected output registers.
    logic [11:0] m_mem [DEPTH];
    int          busy_left = DEPTH;
    logic [11:0] e1_data = 12'h000, e2_data = 12'h000;
    logic        e1_valid = 1'b0, e2_valid = 1'b0;

    always @(posedge clock or posedge reset) begin
        logic [11:0] bits;
        if (reset) begin
            busy_left = DEPTH;
            e1_data = 12'h000; e1_valid = 1'b0;
            e2_data = 12'h000; e2_valid = 1'b0;
        end else begin
            e2_valid = e1_valid;
            if (e1_valid) e2_data = e1_data;
            if (busy_left > 0) begin
                m_mem[DEPTH - busy_left] = CV;
                busy_left--;
            end else begin
                if (write_enable) begin
                    bits = {{4{write_mask[2]}}, {4{write_mask[1]}}, {4{write_mask[0]}}};
                    m_mem[write_address] = (m_mem[write_address] & ~bits) | (write_data & bits);
                end
                if (clear_request) busy_left = DEPTH;
            end
            e1_valid = read_enable;
            if (read_enable) e1_data = m_mem[read_address];
        end
        #1;
        check("busy1", 32'(busy1), 32'(busy_left > 0));
        check("busy2", 32'(busy2), 32'(busy_left > 0));
        check("valid1", 32'(read_valid1), 32'(e1_valid));
        check("data1", 32'(read_data1), 32'(e1_data));
        check("valid2", 32'(read_valid2), 32'(e2_valid));
        check("data2", 32'(read_data2), 32'(e2_data));
    end

    task automatic idle_inputs();
        write_enable = 1'b0; write_mask = 3'b000; read_enable = 1'b0; clear_request = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic measure_busy(input string name);
        int n;
        n = 0;
        while (busy1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(n), 32'd16);
    endtask

    initial begin
        tick(2);
        check("busy_in_reset", 32'(busy1), 32'd1);
        reset = 1'b0;
        measure_busy("busy_len_after_reset");

        // Whole array holds the clear value.
        for (int a = 0; a < DEPTH; a++) begin
            read_enable = 1'b1; read_address = 4'(a);
            tick(1);
            check("clear_word", 32'(read_data1), 32'(12'hABC));
        end
        idle_inputs();

        // Full write then single-lane overwrite.
        write_enable = 1'b1; write_address = 4'd5; write_data = 12'h123; write_mask = 3'b111;
        tick(1);
        write_data = 12'hF0F; write_mask = 3'b010;
        tick(1);
        idle_inputs();
        read_enable = 1'b1; read_address = 4'd5;
        tick(1);
        check("masked_write", 32'(read_data1), 32'(12'h103));
        idle_inputs();

        // Same-edge write and read forwards only the written lane.
        write_enable = 1'b1; write_address = 4'd9; write_data = 12'h120; write_mask = 3'b111;
        tick(1);
        write_data = 12'h777; write_mask = 3'b001;
        read_enable = 1'b1; read_address = 4'd9;
        tick(1);
        check("forward_lat1", 32'(read_data1), 32'(12'h127));
        idle_inputs();
        tick(1);
        check("forward_lat2", 32'(read_data2), 32'(12'h127));
        check("hold_lat1", 32'(read_data1), 32'(12'h127));
        check("gap_valid1", 32'(read_valid1), 32'd0);

        // Distinct words, then reads with gaps.
        for (int a = 0; a < 4; a++) begin
            write_enable = 1'b1; write_mask = 3'b111; write_address = 4'(a); write_data = 12'(16 * (a + 1));
            tick(1);
        end
        idle_inputs();
        read_enable = 1'b1; read_address = 4'd0; tick(1);
        check("lat2_first_pending", 32'(read_valid2), 32'd0);
        read_address = 4'd1; tick(1);
        check("lat2_first_data", 32'(read_data2), 32'(12'h010));
        read_address = 4'd2; tick(1);
        read_enable = 1'b0; tick(1);
        read_enable = 1'b1; read_address = 4'd3; tick(1);
        read_enable = 1'b0; tick(1);
        check("lat2_after_gap", 32'(read_data2), 32'(12'h040));
        tick(1);
        check("lat2_hold", 32'(read_data2), 32'(12'h040));

        // Clear request with a same-edge write, then dropped writes and ignored requests.
        clear_request = 1'b1; write_enable = 1'b1; write_mask = 3'b111;
        write_address = 4'd3; write_data = 12'h555;
        tick(1);
        begin
            int n;
            n = 0;
            while (busy1 && n < 40) begin
                read_enable = 1'b1; read_address = 4'(n);
                @(negedge clock);
                n++;
            end
            idle_inputs();
            check("busy_len_request", 32'(n), 32'd16);
        end
        read_enable = 1'b1; read_address = 4'd3;
        tick(1);
        check("dropped_write", 32'(read_data1), 32'(12'hABC));
        idle_inputs();

        // Reset mid-sweep at clear address 7.
        read_enable = 1'b1; read_address = 4'd9; clear_request = 1'b1;
        tick(1);
        clear_request = 1'b0;
        tick(7);
        check("pre_reset_data", 32'(read_data1), 32'(12'hABC));
        #2 reset = 1'b1;
        #1;
        check("reset_data1", 32'(read_data1), 32'd0);
        check("reset_valid1", 32'(read_valid1), 32'd0);
        check("reset_data2", 32'(read_data2), 32'd0);
        check("reset_busy", 32'(busy1), 32'd1);
        tick(2);
        idle_inputs();
        reset = 1'b0;
        measure_busy("busy_len_after_midreset");
        read_enable = 1'b1; read_address = 4'd15;
        tick(1);
        check("post_reset_word", 32'(read_data1), 32'(12'hABC));
        idle_inputs();
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clearable_dual_port_ram.md
# clearable_dual_port_ram

Parametrised single-clock pixel/palette RAM for the RAMDAC datapath: one write port with per-lane (per-colour-channel) write masks, one read port with selectable 1- or 2-cycle latency and write-first forwarding, plus a built-in clear engine. The clear engine sweeps every word to a constant after reset or on request. It replaces the plain dual-port framebuffer RAM wherever line or palette buffers must start from a known value and support partial colour updates.

## Interface
- DATA_WIDTH, 12: word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 4: bits per write-mask lane (one RGB nibble); LANES = DATA_WIDTH/LANE_WIDTH.
- ADDRESS_SIZE, 13: depth is 2**ADDRESS_SIZE words.
- READ_LATENCY, 1: 1 or 2 cycles from read request to data; other values are illegal.
- CLEAR_VALUE, 0: word written by the clear engine.
- CLEAR_ON_RESET, 1: 1 = start a clear sweep when reset is released.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- write_data  input  DATA_WIDTH  write word.
- write_address  input  ADDRESS_SIZE  write address.
- write_enable  input  1  write request.
- write_mask  input  LANES  lane i set = write bits [i*LANE_WIDTH +: LANE_WIDTH].
- read_address  input  ADDRESS_SIZE  read address.
- read_enable  input  1  read request.
- clear_request  input  1  start clear sweep; sampled only in IDLE.
- read_data  output  DATA_WIDTH  read result.
- read_valid  output  1  read_data carries a requested word this cycle.
- busy  output  1  clear sweep in progress; user writes dropped.

## Operation
- Memory array is not reset; contents are undefined until written or cleared.
- Clear FSM, 2 states:
  - IDLE, with clear_request → CLEARING; clear_address ← 0.
  - CLEARING: each edge writes CLEAR_VALUE to all lanes of memory[clear_address], then increments clear_address.
  - At clear_address == 2**ADDRESS_SIZE-1, that edge performs the write and the FSM returns to IDLE.
  - clear_request in CLEARING is ignored.
- busy = (state == CLEARING).
- User write: on an edge with write_enable=1 and busy=0, each lane whose mask bit is set takes the corresponding write_data lane. Other lanes keep their value. A mask of all-zero writes nothing. A user write while busy=1 is silently dropped.
- An edge accepting clear_request (busy=0) also accepts a user write on the same edge; the sweep then overwrites it.
- Read: on an edge with read_enable=1, memory[read_address] is captured; reads are served during busy as well.
- Write-first forwarding: if the same edge performs a write (user or clear) to read_address, the captured word is per-lane: written lanes take new data, unmasked lanes take old contents.
- read_enable=0: read_data holds its last value; read_valid=0 at the corresponding output cycle.

## Timing
- Async reset assertion forces:
  - read_data = 0, read_valid = 0, clear_address = 0.
  - State = CLEARING if CLEAR_ON_RESET=1, else IDLE; busy follows immediately.
- Reset asserted mid-sweep restarts the sweep at address 0 after release (CLEAR_ON_RESET=1), or abandons it (CLEAR_ON_RESET=0).
- A sweep holds busy high for exactly 2**ADDRESS_SIZE clock cycles. busy falls after the edge writing the last address.
- READ_LATENCY=1: request at edge T → read_data/read_valid updated at edge T.
- READ_LATENCY=2: extra output register; result appears at edge T+1. Pipeline accepts one read every cycle and reset clears both stages.
- A write at edge T is visible to a read captured at edge T (forwarding) and to all later reads.
- Back-to-back reads and writes sustain one each per cycle with no stalls.

## Test plan
- ADDRESS_SIZE=4, CLEAR_VALUE=12'hABC, CLEAR_ON_RESET=1: release reset → busy high exactly 16 cycles; then reading addresses 0..15 returns 12'hABC with read_valid=1.
- write 12'h123 at 5 with mask 3'b111, then 12'hF0F at 5 with mask 3'b010 → read 5 returns 12'h103.
- Same-edge write 12'h777 mask 3'b001 and read at address 9 holding 12'h120 → read_data 12'h127 at that edge (LATENCY=1), or next edge (LATENCY=2).
- During busy: write 12'h555 to address 3 → dropped. After sweep, read 3 returns CLEAR_VALUE. clear_request during sweep does not extend busy beyond 16 cycles.
- Assert reset at clear_address 7 → read_data=0, read_valid=0 immediately. After release, busy lasts a full 16 cycles.
- READ_LATENCY=2, reads to 0,1,2 on consecutive edges, with gaps → read_valid pattern delayed by exactly one edge; read_data holds during gaps.
